// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: pipeline control bits and register specifiers in, stall/flush/forward selects
// and the data-memory request handshake out.
interface hazard_unit_if;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM, memwriteM;
    logic       branchD, pcsrcD, jumpD;
    logic       dmem_ready;
    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushW;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       dmem_req;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM,
               branchD, pcsrcD, jumpD, dmem_ready,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE, dmem_req
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM,
               branchD, pcsrcD, jumpD, dmem_ready,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE, dmem_req
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage MIPS hazard unit: forwarding, load-use/branch stalls, multi-cycle dmem wait FSM
// with timeout, and saturating stall-event counters.
module hazard_unit #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_unit_if.slave     hz,
    output logic             mem_err,
    output logic [CNT_W-1:0] lw_cnt,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mem_cnt
);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_ERR} memState_t;

    memState_t         state, nextState;
    logic [WAIT_W-1:0] waitCnt, nextWaitCnt;
    logic              lwStall, branchStall, accessM, memStall, dmemReq, ctlStall;

    always_comb begin
        hz.forwardAE = 2'b00;
        if (hz.rsE != 5'd0 && hz.regwriteM && hz.rsE == hz.writeregM)      hz.forwardAE = 2'b10;
        else if (hz.rsE != 5'd0 && hz.regwriteW && hz.rsE == hz.writeregW) hz.forwardAE = 2'b01;

        hz.forwardBE = 2'b00;
        if (hz.rtE != 5'd0 && hz.regwriteM && hz.rtE == hz.writeregM)      hz.forwardBE = 2'b10;
        else if (hz.rtE != 5'd0 && hz.regwriteW && hz.rtE == hz.writeregW) hz.forwardBE = 2'b01;
    end

    assign hz.forwardAD = (hz.rsD != 5'd0) && hz.regwriteM && (hz.rsD == hz.writeregM);
    assign hz.forwardBD = (hz.rtD != 5'd0) && hz.regwriteM && (hz.rtD == hz.writeregM);

    assign lwStall = hz.memtoregE && (hz.rtE == hz.rsD || hz.rtE == hz.rtD);
    assign branchStall = hz.branchD &&
        ((hz.regwriteE && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
         (hz.memtoregM && (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)));
    assign accessM = hz.memtoregM | hz.memwriteM;

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        memStall    = 1'b0;
        dmemReq     = 1'b0;
        case (state)
            MEM_IDLE: begin
                dmemReq  = accessM;
                memStall = accessM & ~hz.dmem_ready;
                if (memStall) begin
                    nextState   = MEM_WAIT;
                    nextWaitCnt = '0;
                end
            end
            MEM_WAIT: begin
                dmemReq  = 1'b1;
                memStall = accessM & ~hz.dmem_ready;
                if (hz.dmem_ready)                               nextState = MEM_IDLE;
                else if (waitCnt == WAIT_W'(TIMEOUT - 1))        nextState = MEM_ERR;
                else                                             nextWaitCnt = waitCnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= MEM_IDLE;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // ERR is sticky until reset, so the state decode is the error flag.
    assign mem_err     = (state == MEM_ERR);
    assign hz.dmem_req = dmemReq;

    assign ctlStall  = lwStall | branchStall;
    assign hz.stallF = ctlStall | memStall;
    assign hz.stallD = ctlStall | memStall;
    assign hz.stallE = memStall;
    assign hz.stallM = memStall;
    assign hz.flushE = ctlStall & ~memStall;
    assign hz.flushW = memStall;
    assign hz.flushD = (hz.pcsrcD | hz.jumpD) & ~(ctlStall | memStall);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lw_cnt  <= '0;
            br_cnt  <= '0;
            mem_cnt <= '0;
        end else begin
            if (lwStall && !memStall && lw_cnt != '1)     lw_cnt  <= lw_cnt + 1'b1;
            if (branchStall && !memStall && br_cnt != '1) br_cnt  <= br_cnt + 1'b1;
            if (memStall && mem_cnt != '1)                mem_cnt <= mem_cnt + 1'b1;
        end
    end
endmodule
